pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer; next generation of the fetch-stage PC register.
//  Adds configurable width, reset/trap vectors, stall, a hardware return-address stack (RAS)
//  for call/return, and trap entry/exit with a saved exception PC (EPC).
//  Drives instruction-memory address; control unit supplies pc_sel each cycle.
// PARAMETERS
//  XLEN          32            PC / address width in bits
//  RESET_VECTOR  32'h0000_0000 pc_out value on reset
//  TRAP_VECTOR   32'h0000_0100 pc_out target on trap entry
//  INC_STEP      4             sequential increment
//  RAS_DEPTH     4             return-address-stack entries (>=2, power of 2)
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        asynchronous, active-high reset
//  stall         in   1        hold PC and all state this cycle
//  pc_sel        in   3        next-PC select (encodings below)
//  branch_addr   in   XLEN     branch target
//  jump_addr     in   XLEN     jump/call target; fallback target for RET on empty RAS
//  trap_req      in   1        take trap this cycle
//  pc_out        out  XLEN     current PC (registered)
//  epc           out  XLEN     saved PC of last trap (registered)
//  in_trap       out  1        set on trap entry, cleared by ERET
//  ras_count     out  $clog2(RAS_DEPTH+1)  valid RAS entries
//  ras_overflow  out  1        one-cycle pulse: CALL pushed onto full RAS
//  ras_underflow out  1        one-cycle pulse: RET with empty RAS
//  misalign      out  1        one-cycle pulse: misaligned target trapped (feature only)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation): pc_out=RESET_VECTOR, epc=0, in_trap=0,
//    ras_count=0, all pulse outputs 0; RAS contents don't-care.
//  All state updates on rising clk; priority: reset > trap_req > stall > pc_sel.
//  pc_sel: 000 INC pc+INC_STEP | 001 BRANCH branch_addr | 010 JUMP jump_addr | 011 HOLD pc
//    100 CALL push pc+INC_STEP, pc<=jump_addr | 101 RET pop, pc<=top | 110 ERET pc<=epc,
//    in_trap<=0 | 111 reserved -> treated as INC.
//  Arithmetic modulo 2^XLEN; pc+INC_STEP wraps silently (all-ones region -> low addresses).
//  trap_req: epc<=pc_out, pc<=TRAP_VECTOR, in_trap<=1; RAS untouched; overrides stall and
//    pc_sel; nested trap overwrites epc.
//  stall (no trap): pc, epc, in_trap, RAS unchanged; no pulses.
//  RAS circular: CALL on full RAS overwrites oldest entry, ras_count stays RAS_DEPTH,
//    ras_overflow=1 for that cycle. RET on empty: pc<=jump_addr, ras_count stays 0,
//    ras_underflow=1. Pulses are registered, valid the cycle after the causing edge.
//  Latency: one cycle pc_sel -> pc_out; no combinational path from inputs to outputs.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: any BRANCH/JUMP/CALL/RET/ERET target with addr[1:0]!=0
//    is trapped instead of taken: epc<=pc_out, pc<=TRAP_VECTOR, in_trap<=1, misalign
//    pulses; CALL push/RET pop suppressed. INC unaffected.
//  Not defined: targets taken verbatim; misalign tied 0.
// STRUCTURE
//  pc_pkg: pc_sel encoding enum (PC_INC..PC_ERET), INC_STEP default, vector defaults.
//  Sub-module pc_ras: circular stack, RAS_DEPTH x XLEN, push/pop/count/overflow/underflow.
//  Top holds PC/EPC registers, next-PC mux, priority logic, optional align check.
// TESTING
//  1 reset mid-run with pc=0x40, ras_count=2 -> pc_out=0x0, ras_count=0, epc=0 same cycle.
//  2 INC x3 then BRANCH 0x200 then HOLD -> pc 0x4,0x8,0xC,0x200,0x200.
//  3 pc=0x10 CALL 0x80, pc=0x84 CALL 0xC0, RET, RET -> 0x80,0xC0,0x88,0x14; count 1,2,1,0.
//  4 RAS_DEPTH=4: 5 CALLs -> ras_overflow on 5th; 5 RETs -> 4 correct pops, 5th underflow.
//  5 pc=0x30 trap_req with stall=1 -> pc=0x100, epc=0x30, in_trap=1; ERET -> pc=0x30.
//  6 PC_ALIGN_CHECK_EN, pc=0x8 JUMP 0x1002 -> pc=0x100, epc=0x8, misalign one pulse.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
// Contents: the pc_sel encoding and the default width, vectors, step and RAS depth.
// Optional feature macro PC_ALIGN_CHECK_EN is consumed by pc_sequencer, not here.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        PC_INC    = 3'b000,
        PC_BRANCH = 3'b001,
        PC_JUMP   = 3'b010,
        PC_HOLD   = 3'b011,
        PC_CALL   = 3'b100,
        PC_RET    = 3'b101,
        PC_ERET   = 3'b110,
        PC_RSVD   = 3'b111
    } pc_sel_e;

    localparam int unsigned PC_XLEN_DEF         = 32;
    localparam int unsigned PC_INC_STEP_DEF     = 4;
    localparam int unsigned PC_RAS_DEPTH_DEF    = 4;
    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0100;

    // Selects whose next PC comes from an explicit target rather than pc+step / pc.
    function automatic logic is_redirect(input pc_sel_e sel);
        return (sel == PC_BRANCH) || (sel == PC_JUMP) || (sel == PC_CALL) ||
               (sel == PC_RET) || (sel == PC_ERET);
    endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack, DEPTH x XLEN; a push onto a full stack drops the oldest entry.
// Ports: push_i/pop_i (mutually exclusive), push_dat_i in; top_o, count_o, empty_o, and
// registered one-cycle overflow_o/underflow_o pulses out. Latency: one cycle, no backpressure.
module pc_sequencer_ras
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = PC_XLEN_DEF,
    parameter int unsigned DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [XLEN-1:0]                push_dat_i,
    output logic [XLEN-1:0]                top_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           empty_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;        // next write slot; top lives at ptr_q-1
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;
    logic             full;

    assign full        = (cnt_q == CNT_W'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign top_o       = mem_q[ptr_q - PTR_W'(1)];
    assign count_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= push_i && full;
            unf_q <= pop_i && empty_o;
            if (push_i) begin
                // Power-of-two depth: the pointer wraps naturally onto the oldest slot.
                ptr_q <= ptr_q + PTR_W'(1);
                if (!full) cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop_i && !empty_o) begin
                ptr_q <= ptr_q - PTR_W'(1);
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC mux, trap entry/ERET with saved EPC, call/return stack.
// Ports: clk/reset, stall, pc_sel, branch_addr, jump_addr, trap_req in; pc_out, epc, in_trap,
// ras_count, ras_overflow/underflow, misalign out (all registered). Macro: PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = PC_XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR_DEF),
    parameter int unsigned     INC_STEP     = PC_INC_STEP_DEF,
    parameter int unsigned     RAS_DEPTH    = PC_RAS_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [2:0]                     pc_sel,
    input  logic [XLEN-1:0]                branch_addr,
    input  logic [XLEN-1:0]                jump_addr,
    input  logic                           trap_req,
    output logic [XLEN-1:0]                pc_out,
    output logic [XLEN-1:0]                epc,
    output logic                           in_trap,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           misalign
);
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
    logic            in_trap_q, in_trap_d, misalign_q, misalign_d;
    logic [XLEN-1:0] pc_inc, target, ras_top;
    logic            ras_empty, sel_push, sel_pop, ras_push, ras_pop, misalign_hit;
    pc_sel_e         sel;

    pc_sequencer_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .rst         (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_dat_i  (pc_inc),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .empty_o     (ras_empty),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    always_comb begin
        sel      = pc_sel_e'(pc_sel);
        pc_inc   = pc_q + XLEN'(INC_STEP);   // wraps modulo 2^XLEN
        target   = pc_inc;
        sel_push = 1'b0;
        sel_pop  = 1'b0;
        case (sel)
            PC_BRANCH: target = branch_addr;
            PC_JUMP:   target = jump_addr;
            PC_HOLD:   target = pc_q;
            PC_CALL: begin
                target   = jump_addr;
                sel_push = 1'b1;
            end
            PC_RET: begin
                // Empty stack falls back to the jump target supplied by control.
                target  = ras_empty ? jump_addr : ras_top;
                sel_pop = 1'b1;
            end
            PC_ERET:   target = epc_q;
            default:   target = pc_inc;
        endcase

        misalign_hit = ALIGN_EN && is_redirect(sel) && (target[1:0] != 2'b00);

        pc_d       = pc_q;
        epc_d      = epc_q;
        in_trap_d  = in_trap_q;
        misalign_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (trap_req) begin
            epc_d     = pc_q;
            pc_d      = TRAP_VECTOR;
            in_trap_d = 1'b1;
        end else if (!stall) begin
            if (misalign_hit) begin
                // Misaligned target becomes a trap; the stack is left untouched.
                epc_d      = pc_q;
                pc_d       = TRAP_VECTOR;
                in_trap_d  = 1'b1;
                misalign_d = 1'b1;
            end else begin
                pc_d     = target;
                ras_push = sel_push;
                ras_pop  = sel_pop;
                if (sel == PC_ERET) in_trap_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            in_trap_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            in_trap_q  <= in_trap_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out   = pc_q;
    assign epc      = epc_q;
    assign in_trap  = in_trap_q;
    assign misalign = misalign_q;

endmodule
